param_codeblock: RTL and testbench
==================================

# param_codeblock

Parametrised successor of the fixed two-bit source codeblock used in the asynchronous-HyperLTL compiler-optimisation case studies. It executes the loop `x = secret; repeat ITER: publish x mod MOD; x = x + x` as an explicit step machine with a stutter input. The loop runs in one of two modes, selected per run: source (unoptimised) or loop-peeled (target). Both modes must publish the identical `public_out` sequence while taking different numbers of steps. This is the property the asynchronous hyperproperty checks are built against.

## Interface
- `SEC_W`, default 2: width of `secret_in`.
- `X_W`, default 4: width of the accumulator `x`. All arithmetic is mod 2^X_W.
- `ITER`, default 3: loop trip count. Legal range is ≥0.
- `MOD`, default 3: output modulus. Must be ≥1.
- `OUT_W`, default 2: width of `public_out`. Must be ≥ clog2(MOD).
- `clk`, in, 1: clock. All state changes on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `stutter_in`, in, 1: 1 freezes the program for this cycle.
- `peel_in`, in, 1: mode select. Sampled only in step 0. 0 = source, 1 = peeled.
- `secret_in`, in, SEC_W: secret value. Sampled only in the load step.
- `public_out`, out, OUT_W: last published value.
- `out_valid`, out, 1: one-cycle pulse, asserted in the cycle after each `public_out` write.
- `stutter`, out, 1: `stutter_in` registered.
- `done`, out, 1: high while the machine is in the terminal step.

## Operation
- Internal registers:
  - `step`: 4-bit step counter.
  - `x`: X_W bits.
  - `k`: clog2(ITER+1) bits, minimum 1.
  - `mode`: 1 bit.
- Every edge: `stutter <= stutter_in`.
- If `stutter_in` = 1:
  - `step`, `x`, `k`, `mode` and `public_out` hold.
  - `out_valid` <= 0.
- Steps advance only when `stutter_in` = 0. Each active edge performs exactly one step.
- Source-mode steps:
  - S0: `mode <= peel_in`; go to S1.
  - S1: `x <= 0`; go to S2.
  - S2: `k <= 0`. Next is P1 if `peel_in` was latched as 1 and ITER > 0; otherwise S3.
  - S3: if `k < ITER` go to S4, else go to S9.
  - S4: if `k == 0` go to S5, else go to S6.
  - S5: `x <= zero-extend(secret_in)`, truncated to X_W; go to S7.
  - S6: `x <= x + x`, wrapping mod 2^X_W; go to S7.
  - S7: `k <= k + 1`; go to S8.
  - S8: `public_out <= x mod MOD` (unsigned, resized to OUT_W); `out_valid <= 1`; go to S3.
  - S9: terminal. All registers hold; `done` = 1. Only `rst` leaves S9.
- Peeled-mode steps (first iteration hoisted out of the loop):
  - P1: `x <= secret_in`, same extension rule as S5; go to P2.
  - P2: `k <= k + 1`; go to P3.
  - P3: publish, same as S8; go to S3.
  - While `mode` = 1, S3 with `k < ITER` goes directly to S6. S4 and S5 are never visited.
- `out_valid` is 0 on every edge that does not execute S8 or P3.
- `done` = (`step` == S9), registered-state decode.
- Unused `step` encodings go to S9 on the next active edge (safe trap).
- `peel_in` changes after S0 have no effect.
- `secret_in` changes outside S5/P1 have no effect.

## Timing
- Reset values:
  - `step` = S0.
  - `x`, `k`, `mode` = 0.
  - `public_out` = 0.
  - `out_valid` = 0.
  - `stutter` = 0.
  - `done` = 0.
- `rst` dominates `stutter_in` and any step. Reset mid-run (including in S9) restarts at S0 on the next edge.
- Active steps to reach S9:
  - Source mode: 3 + 5·ITER + 1.
  - Peeled mode: 3 + 3 + 4·(ITER−1) + 1 when ITER > 0.
  - With ITER = 0: 4 steps in both modes.
- Defaults (ITER = 3): source = 19 active edges, peeled = 15.
- Each stutter cycle delays every later event by exactly one cycle.
- Publish pulses occur on the edge after S8/P3, aligned with the new `public_out` value.

## Test plan
- Defaults, `peel_in` = 0, `secret_in` = 2, no stutter, after `rst`:
  - `public_out` sequence 2, 1, 2 (x = 2, 4, 8).
  - Exactly 3 `out_valid` pulses.
  - `done` rises after 19 active edges.
- Same stimulus with `peel_in` = 1:
  - Identical sequence 2, 1, 2.
  - `done` after 15 active edges.
  - S4/S5 never entered.
- `secret_in` = 3, both modes:
  - Outputs 0, 0, 0 (x = 3, 6, 12).
  - `secret_in` changed to 1 after the load step leaves the results unchanged.
- ITER = 4, `secret_in` = 3:
  - x wraps 3, 6, 12, 8; outputs 0, 0, 0, 2.
  - `done` after 24 active edges (source) and 19 (peeled).
- Random stutter pattern with 7 stutter cycles, defaults, source mode:
  - Same output values as the no-stutter run.
  - `done` at cycle 26.
  - `stutter` equals `stutter_in` delayed by 1.
  - No `out_valid` pulse on any stutter cycle.
- ITER = 0: in either mode, `done` after 4 edges, with no `out_valid` pulse and `public_out` = 0.
- `rst` asserted mid-loop (e.g. after the 2nd publish) while also stuttering:
  - All outputs return to their reset values on the next edge.
  - The rerun reproduces the full sequence.

Source files
------------

// File: rtl/param_codeblock.sv
// param_codeblock: step machine for `x = secret; repeat ITER: publish x mod MOD; x = x + x`.
// A run executes in source order or with the first iteration peeled. Both orders publish
// the same values but take a different number of steps. A stutter cycle freezes the program.
module param_codeblock #(
  parameter int unsigned SEC_W = 2,
  parameter int unsigned X_W   = 4,
  parameter int unsigned ITER  = 3,
  parameter int unsigned MOD   = 3,
  parameter int unsigned OUT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stutter_in,
  input  logic             peel_in,
  input  logic [SEC_W-1:0] secret_in,
  output logic [OUT_W-1:0] public_out,
  output logic             out_valid,
  output logic             stutter,
  output logic             done
);

  localparam int unsigned    K_W     = (ITER != 0) ? $clog2(ITER + 1) : 1;
  localparam logic [K_W-1:0] ITER_K  = K_W'(ITER);
  localparam logic           ITER_NZ = (ITER != 0);

  // S0..S9 are the source program. P1..P3 are the hoisted first iteration.
  typedef enum logic [3:0] {
    S0 = 4'd0, S1 = 4'd1, S2 = 4'd2, S3 = 4'd3, S4 = 4'd4,
    S5 = 4'd5, S6 = 4'd6, S7 = 4'd7, S8 = 4'd8, S9 = 4'd9,
    P1 = 4'd10, P2 = 4'd11, P3 = 4'd12
  } step_t;

  step_t            step, step_nxt;
  logic [X_W-1:0]   x, x_nxt;
  logic [K_W-1:0]   k, k_nxt;
  logic             mode, mode_nxt;
  logic             pub_we;
  logic             k_lt_iter;
  logic [X_W-1:0]   secret_x;
  logic [OUT_W-1:0] x_mod;

  // Zero-extend or truncate the secret to the accumulator width.
  assign secret_x = X_W'(secret_in);
  assign x_mod    = OUT_W'(32'(x) % MOD);
  // k counts up from 0 and stops at ITER, so "k < ITER" reduces to "k != ITER".
  assign k_lt_iter = (k != ITER_K);

  // Next step and next register values for one non-stuttered edge.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    step_nxt = S9;
    x_nxt    = x;
    k_nxt    = k;
    mode_nxt = mode;
    pub_we   = 1'b0;
    case (step)
      S0: begin mode_nxt = peel_in;  step_nxt = S1; end
      S1: begin x_nxt = '0;          step_nxt = S2; end
      S2: begin
        k_nxt    = '0;
        step_nxt = (mode && ITER_NZ) ? P1 : S3;
      end
      S3: begin
        if (k_lt_iter) step_nxt = mode ? S6 : S4;
        else           step_nxt = S9;
      end
      S4: step_nxt = (k == '0) ? S5 : S6;
      S5: begin x_nxt = secret_x;    step_nxt = S7; end
      S6: begin x_nxt = x + x;       step_nxt = S7; end
      S7: begin k_nxt = k + 1'b1;    step_nxt = S8; end
      S8: begin pub_we = 1'b1;       step_nxt = S3; end
      P1: begin x_nxt = secret_x;    step_nxt = P2; end
      P2: begin k_nxt = k + 1'b1;    step_nxt = P3; end
      P3: begin pub_we = 1'b1;       step_nxt = S3; end
      S9: step_nxt = S9;
      // Unused encodings fall into the terminal step.
      default: step_nxt = S9;
    endcase
  end

  // Program state, with reset taking priority over stutter and stutter freezing every step.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      step       <= S0;
      x          <= '0;
      k          <= '0;
      mode       <= 1'b0;
      public_out <= '0;
      out_valid  <= 1'b0;
      stutter    <= 1'b0;
    end else begin
      stutter <= stutter_in;
      if (stutter_in) begin
        out_valid <= 1'b0;
      end else begin
        step      <= step_nxt;
        x         <= x_nxt;
        k         <= k_nxt;
        mode      <= mode_nxt;
        out_valid <= pub_we;
        if (pub_we) public_out <= x_mod;
      end
    end
  end

  // Terminal-step decode of the registered step.
  assign done = (step == S9);

endmodule

// File: tb/tb_param_codeblock.sv
// Scoreboard bench for param_codeblock. Three instances (ITER = 3, 4, 0) share stimulus.
// A reference model fills per-instance expected queues. A negedge monitor checks every
// publish, the stutter echo and the step count at which done rises.
module tb_param_codeblock;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       stutter_in;
  logic       peel_in;
  logic [1:0] secret_in;
  logic [1:0] pub  [N];
  logic       vld  [N];
  logic       dn   [N];
  logic       stut [N];

  always #5 clk = ~clk;

  param_codeblock #(.ITER(3)) dut_i3 (
    .clk(clk), .rst(rst), .stutter_in(stutter_in), .peel_in(peel_in), .secret_in(secret_in),
    .public_out(pub[0]), .out_valid(vld[0]), .stutter(stut[0]), .done(dn[0]));
  param_codeblock #(.ITER(4)) dut_i4 (
    .clk(clk), .rst(rst), .stutter_in(stutter_in), .peel_in(peel_in), .secret_in(secret_in),
    .public_out(pub[1]), .out_valid(vld[1]), .stutter(stut[1]), .done(dn[1]));
  param_codeblock #(.ITER(0)) dut_i0 (
    .clk(clk), .rst(rst), .stutter_in(stutter_in), .peel_in(peel_in), .secret_in(secret_in),
    .public_out(pub[2]), .out_valid(vld[2]), .stutter(stut[2]), .done(dn[2]));

  int   tests = 0;
  int   failures = 0;
  int   active_edges = 0;
  int   cycles = 0;
  logic st_at_edge = 1'b0;
  logic rst_at_edge = 1'b1;
  bit   done_seen [N];
  int   pub_count [N];
  int   exp_done  [N];
  int   exp_last  [N];
  int   q0[$], q1[$], q2[$];
  bit   want_cycle26 = 1'b0;
  bit   pat [26];

  function automatic int iter_of(input int i);
    case (i)
      0:       return 3;
      1:       return 4;
      default: return 0;
    endcase
  endfunction

  // Active edges to reach the terminal step.
  function automatic int done_edges(input int iter, input bit peel);
    if (iter == 0) return 4;
    return peel ? (3 + 3 + 4 * (iter - 1) + 1) : (3 + 5 * iter + 1);
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s [dut%0d]: got %0d, expected %0d (cycle %0d)", name, idx, act, exp, cycles);
    end
  endtask

  task automatic push_exp(input int i, input int v);
    case (i)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic pop_exp(input int i, output int v, output bit ok);
    ok = 1'b0;
    v  = 0;
    case (i)
      0:       if (q0.size() > 0) begin v = q0.pop_front(); ok = 1'b1; end
      1:       if (q1.size() > 0) begin v = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin v = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  function automatic int q_size(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  // Model: x = secret; repeat ITER { publish x % 3; x = 2x mod 16 }.
  task automatic load_expected(input bit peel, input int sec);
    q0.delete(); q1.delete(); q2.delete();
    for (int i = 0; i < N; i++) begin
      int xv;
      int last;
      xv   = sec;
      last = 0;
      for (int j = 0; j < iter_of(i); j++) begin
        push_exp(i, xv % 3);
        last = xv % 3;
        xv   = (xv * 2) % 16;
      end
      exp_done[i] = done_edges(iter_of(i), peel);
      exp_last[i] = last;
    end
  endtask

  // Advance one clock with the given stutter value. Inputs change 1 time unit after the edge.
  task automatic tick(input logic st);
    stutter_in = st;
    @(posedge clk);
    st_at_edge  = st;
    rst_at_edge = rst;
    if (!rst) begin
      cycles++;
      if (!st) active_edges++;
    end
    #1;
  endtask

  task automatic do_reset(input logic st);
    rst = 1'b1;
    tick(st);
    rst = 1'b0;
    q0.delete(); q1.delete(); q2.delete();
    active_edges = 0;
    cycles       = 0;
    for (int i = 0; i < N; i++) begin
      done_seen[i] = 1'b0;
      pub_count[i] = 0;
    end
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check("reset_public_out", i, 32'(pub[i]), 0);
      check("reset_out_valid",  i, 32'(vld[i]), 0);
      check("reset_stutter",    i, 32'(stut[i]), 0);
      check("reset_done",       i, 32'(dn[i]), 0);
    end
  endtask

  task automatic gen_pat();
    int n;
    n = 0;
    for (int c = 0; c < 26; c++) pat[c] = 1'b0;
    while (n < 7) begin
      int p;
      p = int'($urandom_range(24));
      if (!pat[p]) begin
        pat[p] = 1'b1;
        n++;
      end
    end
  endtask

  // One run. chg_sec >= 0 rewrites secret_in once the load step is past. abort_at > 0 stops
  // the run after that many publishes from the ITER=3 instance, leaving the machine mid-loop.
  task automatic run(input bit peel, input int sec, input int chg_sec, input int stut_pct,
                     input int abort_at, input bit use_pat);
    int  guard;
    bit  all_done;
    do_reset(1'b1);
    peel_in   = peel;
    secret_in = 2'(sec);
    load_expected(peel, sec);
    guard    = 0;
    all_done = 1'b0;
    while (!all_done && guard < 400) begin
      logic st;
      if (abort_at > 0 && pub_count[0] >= abort_at) return;
      if (active_edges >= 1) peel_in = 1'($urandom);
      if (chg_sec >= 0 && active_edges >= 8) secret_in = 2'(chg_sec);
      if (use_pat) st = (cycles < 26) ? pat[cycles] : 1'b0;
      else         st = ($urandom_range(99) < stut_pct);
      tick(st);
      guard++;
      @(negedge clk);
      all_done = done_seen[0] && done_seen[1] && done_seen[2];
    end
    check("run_complete", -1, 32'(all_done), 1);
    for (int i = 0; i < N; i++) check("pending_publishes", i, q_size(i), 0);
    // The terminal step must hold, with or without stutter.
    for (int c = 0; c < 3; c++) tick(1'($urandom));
    for (int i = 0; i < N; i++) check("done_holds", i, 32'(dn[i]), 1);
  endtask

  // Monitor: stutter echo, no publish on stutter, publish values, done timing.
  always @(negedge clk) begin
    int e;
    bit ok;
    for (int i = 0; i < N; i++) begin
      check("stutter_echo", i, 32'(stut[i]), rst_at_edge ? 0 : 32'(st_at_edge));
      if (st_at_edge && !rst_at_edge) check("no_valid_on_stutter", i, 32'(vld[i]), 0);
      if (vld[i] === 1'b1) begin
        pop_exp(i, e, ok);
        if (!ok) check("unexpected_valid", i, 1, 0);
        else     check("publish_value", i, 32'(pub[i]), e);
        pub_count[i]++;
      end
      if (dn[i] === 1'b1 && !done_seen[i] && !rst_at_edge) begin
        done_seen[i] = 1'b1;
        check("done_active_edges", i, active_edges, exp_done[i]);
        check("final_public_out", i, 32'(pub[i]), exp_last[i]);
        if (i == 0 && want_cycle26) check("done_cycle", i, cycles, 26);
      end
    end
  end

  initial begin
    rst        = 1'b1;
    stutter_in = 1'b0;
    peel_in    = 1'b0;
    secret_in  = '0;

    // Directed: secret 2 in both modes, then secret 3 with a late secret change.
    run(1'b0, 2, -1, 0, 0, 1'b0);
    run(1'b1, 2, -1, 0, 0, 1'b0);
    run(1'b0, 3, 1, 0, 0, 1'b0);
    run(1'b1, 3, 1, 0, 0, 1'b0);

    // Seven stutter cycles in a source run: ITER=3 instance finishes on cycle 26.
    gen_pat();
    want_cycle26 = 1'b1;
    run(1'b0, 2, -1, 0, 0, 1'b1);
    want_cycle26 = 1'b0;

    // Abort after the second publish. The next run resets while stuttering and reruns.
    run(1'b0, 2, -1, 0, 2, 1'b0);
    run(1'b0, 2, -1, 0, 0, 1'b0);
    run(1'b1, int'($urandom_range(3)), -1, 20, 2, 1'b0);
    run(1'b1, 2, -1, 20, 0, 1'b0);

    // Randomized runs.
    for (int r = 0; r < 8; r++) begin
      int cs;
      cs = ($urandom_range(1) == 1) ? int'($urandom_range(3)) : -1;
      run(1'($urandom), int'($urandom_range(3)), cs, 25, 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
